// File: rtl/h_u_serial_rcs.sv
// h_u_serial_rcs: bit-serial unsigned ripple-borrow subtractor.
// Computes out = {borrow, a - b} one bit per clock through a single full-subtractor cell,
// LSB first, between a valid/ready producer and a valid/ready consumer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   block idle and able to accept operands
//   a, b       N-bit unsigned minuend / subtrahend
//   out_valid  out holds a completed result
//   out_ready  consumer accepts the result
//   out        {borrow, difference}, N+1 bits
//
// Configuration macro: H_U_SERIAL_RCS_SAT_EN
//   defined   -> when the final borrow is 1 the difference is forced to 0 (out = {1, 0...0})
//   undefined -> wrapping (N+1)-bit two's complement result
module h_u_serial_rcs #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q, b_q, diff_q;
  logic            bor_q;
  logic [CntW-1:0] cnt_q;
  logic [N:0]      out_q;
  logic            out_valid_q;

  logic            ai, bi, d_bit, bor_d, last_bit;
  logic [N-1:0]    diff_d;
  logic [N:0]      result_d;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    ai       = a_q[0];
    bi       = b_q[0];
    d_bit    = ai ^ bi ^ bor_q;
    bor_d    = (~ai & bi) | (~(ai ^ bi) & bor_q);
    // Difference bits enter from the MSB end so after N shifts bit 0 sits at diff[0].
    diff_d        = diff_q >> 1;
    diff_d[N-1]   = d_bit;
    last_bit      = (cnt_q == CntW'(N - 1));
    result_d      = {bor_d, diff_d};
`ifdef H_U_SERIAL_RCS_SAT_EN
    if (bor_d) begin
      result_d = {1'b1, {N{1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      bor_q       <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            diff_q  <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_d;
          bor_q  <= bor_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last_bit) begin
            out_q       <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // out_q is left untouched so it holds until the next result loads.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_h_u_serial_rcs.sv
module tb_h_u_serial_rcs;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;  // 0: out_ready low, 1: high, 2: random

  logic [N:0] exp_q[$];
  int         pop_cyc[$];

  h_u_serial_rcs #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = $urandom_range(0, 1) == 1;
    endcase
  end

  // Reference: (a - b) modulo 2^(N+1), or saturated to {1, 0} when a < b.
  function automatic logic [N:0] model(input int av, input int bv);
    int diff;
    diff = av - bv;
`ifdef H_U_SERIAL_RCS_SAT_EN
    if (av < bv) diff = 1 << N;
`endif
    return diff[N:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h required none (cycle %0d)", out, cyc);
      end else begin
        check("result", 32'(out), 32'(exp_q.pop_front()));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic issue(input int av, input int bv);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("issue_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    a = N'(av);
    b = N'(bv);
    @(posedge clk);
    exp_q.push_back(model(av, bv));
    #1;
    in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc, k, saw;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);

    // Basic subtract with latency measurement
    rdy_mode = 1;
    issue(9, 5);
    acc = cyc;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(cyc - acc), 32'(N));
    check("basic_value", 32'(out), 32'(model(9, 5)));
    @(negedge clk);
    check("ready_after_handshake", 32'(in_ready), 32'd1);

    // Borrow
    issue(3, 7);
    drain();

    // Extremes back-to-back
    pop_cyc.delete();
    issue(15, 0);
    issue(0, 15);
    issue(6, 6);
    drain();
    check("b2b_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("b2b_spacing0", 32'(pop_cyc[1] - pop_cyc[0]), 32'(N + 2));
      check("b2b_spacing1", 32'(pop_cyc[2] - pop_cyc[1]), 32'(N + 2));
    end

    // Backpressure
    rdy_mode = 0;
    @(posedge clk);
    issue(5, 2);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b1;
    a = 4'd1;
    b = 4'd1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out", 32'(out), 32'(model(5, 2)));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();
    saw = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("bp_no_extra", 32'(saw), 32'd0);

    // Mid-operation reset
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'd12;
    b = 4'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    rst_n = 1'b1;
    saw = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("mid_rst_no_result", 32'(saw), 32'd0);
    issue(12, 3);
    drain();

    // Randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      issue($urandom_range(0, (1 << N) - 1), $urandom_range(0, (1 << N) - 1));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule
